ledstrip_frame_arbiter: RTL and testbench



---
 rtl/ledstrip_frame_arbiter.sv | 149 ++++++++++++++
 tb/tb_ledstrip_frame_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ledstrip_frame_arbiter.sv
// Round-robin frame arbiter in front of a single WS2812B serializer: grants one whole
// frame per source, feeds it pixel by pixel, then enforces an idle holdoff.
module ledstrip_frame_arbiter #(
    parameter int NUM_LEDS = 280,
    parameter int DATA_W   = 24,
    parameter int HOLDOFF  = 1024,
    parameter int IDX_W    = $clog2(NUM_LEDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    output logic [1:0]        grant,
    output logic [IDX_W-1:0]  pix_index,
    input  logic [DATA_W-1:0] src0_data,
    input  logic              src0_valid,
    output logic              src0_ready,
    input  logic [DATA_W-1:0] src1_data,
    input  logic              src1_valid,
    output logic              src1_ready,
    output logic [DATA_W-1:0] led_data,
    output logic              led_valid,
    output logic              led_latch,
    input  logic              led_ready,
    output logic              frame_done,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    // Handshakes: a source pixel moves when src*_valid && src*_ready are both high on a
    // rising edge; valid may not depend on ready. Toward the serializer, led_valid is
    // held with stable led_data until led_ready has been seen high and then low again
    // (the serializer has latched the pixel and started shifting).

    localparam int                CNT_W     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_STARTED = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         grant_nxt;
    logic               last_grant, last_grant_nxt;
    logic [IDX_W-1:0]   pix_index_nxt;
    logic [DATA_W-1:0]  led_data_nxt;
    logic               led_valid_nxt;
    logic               led_latch_nxt;
    logic               frame_done_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               pick_src1;
    logic               src_valid_g;
    logic [DATA_W-1:0]  src_data_g;
    logic               is_last;

    assign src_valid_g = grant[1] ? src1_valid : (grant[0] & src0_valid);
    assign src_data_g  = grant[1] ? src1_data : src0_data;
    assign is_last     = (pix_index == LAST_IDX);
    // On a tie, the source that did not own the previous frame wins.
    assign pick_src1   = (req == 2'b10) || ((req == 2'b11) && !last_grant);

    assign src0_ready = (state == S_FETCH) && grant[0];
    assign src1_ready = (state == S_FETCH) && grant[1];
    assign busy       = (state != S_IDLE);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            pix_index  <= '0;
            led_data   <= '0;
            led_valid  <= 1'b0;
            led_latch  <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            pix_index  <= pix_index_nxt;
            led_data   <= led_data_nxt;
            led_valid  <= led_valid_nxt;
            led_latch  <= led_latch_nxt;
            frame_done <= frame_done_nxt;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        pix_index_nxt  = pix_index;
        led_data_nxt   = led_data;
        led_valid_nxt  = led_valid;
        led_latch_nxt  = led_latch;
        frame_done_nxt = 1'b0;
        cnt_nxt        = cnt;
        case (state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    grant_nxt      = pick_src1 ? 2'b10 : 2'b01;
                    last_grant_nxt = pick_src1;
                    pix_index_nxt  = '0;
                    state_nxt      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (src_valid_g) begin
                    led_data_nxt  = src_data_g;
                    led_valid_nxt = 1'b1;
                    led_latch_nxt = is_last;
                    state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (led_ready) state_nxt = S_STARTED;
            end
            S_STARTED: begin
                // Ready falling means the serializer has taken this pixel.
                if (!led_ready) begin
                    led_valid_nxt = 1'b0;
                    led_latch_nxt = 1'b0;
                    if (is_last) begin
                        frame_done_nxt = 1'b1;
                        grant_nxt      = 2'b00;
                        cnt_nxt        = HOLD_LOAD;
                        state_nxt      = S_HOLDOFF;
                    end else begin
                        pix_index_nxt = pix_index + IDX_W'(1);
                        state_nxt     = S_FETCH;
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt == '0) state_nxt = S_IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ledstrip_frame_arbiter.sv
// Directed bench for ledstrip_frame_arbiter (NUM_LEDS=4, HOLDOFF=8): serializer model,
// source drivers, pixel/grant scoreboard and a single summary line.
module tb_ledstrip_frame_arbiter;
    localparam int NUM_LEDS = 4;
    localparam int DATA_W   = 24;
    localparam int HOLDOFF  = 8;
    localparam int IDX_W    = 2;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic [IDX_W-1:0]  pix_index;
    logic [DATA_W-1:0] src0_data, src1_data;
    logic              src0_valid, src1_valid;
    logic              src0_ready, src1_ready;
    logic [DATA_W-1:0] led_data;
    logic              led_valid, led_latch, led_ready;
    logic              frame_done, busy;
    logic [2:0]        state_dbg;

    ledstrip_frame_arbiter #(.NUM_LEDS(NUM_LEDS), .DATA_W(DATA_W), .HOLDOFF(HOLDOFF), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .pix_index(pix_index),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
        .led_data(led_data), .led_valid(led_valid), .led_latch(led_latch), .led_ready(led_ready),
        .frame_done(frame_done), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] src0_tab [4] = '{24'h000011, 24'h000022, 24'h000033, 24'h000044};
    logic [DATA_W-1:0] src1_tab [4] = '{24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004};

    logic [31:0] exp_q[$];
    logic [1:0]  exp_grant_q[$];

    int          xfer0 = 0, xfer1 = 0, grant_cnt = 0, frame_cnt = 0;
    int          pix_in_frame = 0, since_fd = 0;
    bit          have_fd = 0, prev_valid = 0, prev_fd = 0;
    logic [1:0]  prev_grant = 2'b00, cur_owner = 2'b00;
    logic [31:0] held = '0;
    logic [31:0] exp_v;

    bit ser_auto = 1;
    int ser_seen = 0, ser_busy = 0;
    bit stall_armed = 0, stall_active = 0;
    int stall_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input bit src);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({7'b0, (i == 3), (src ? src1_tab[i] : src0_tab[i])});
    endtask

    // ---------------- serializer model and source drivers ----------------
    // Ready drops two cycles after a pixel is offered, comes back five cycles later.
    always @(posedge clk) begin
        #1;
        if (ser_auto) begin
            if (ser_busy > 0) begin
                ser_busy--;
                if (ser_busy == 0) led_ready = 1'b1;
            end else if (led_valid && led_ready) begin
                ser_seen++;
                if (ser_seen == 2) begin
                    led_ready = 1'b0;
                    ser_busy  = 5;
                    ser_seen  = 0;
                end
            end else begin
                ser_seen = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        src0_data = src0_tab[pix_index];
        src1_data = src1_tab[pix_index];
        if (stall_armed && grant == 2'b10 && pix_index == 2'd2 && src1_ready) begin
            stall_armed  = 0;
            stall_active = 1;
            stall_cnt    = 0;
            src1_valid   = 1'b0;
        end else if (stall_active) begin
            stall_cnt++;
            if (stall_cnt == 20) begin
                stall_active = 0;
                src1_valid   = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 0;
            prev_grant = 2'b00;
            prev_fd    = 0;
            have_fd    = 0;
        end else begin
            if (src0_valid && src0_ready) xfer0++;
            if (src1_valid && src1_ready) xfer1++;
            check("rdy0_own", {31'b0, src0_ready & ~grant[0]}, 0);
            check("rdy1_own", {31'b0, src1_ready & ~grant[1]}, 0);
            if (led_valid && !prev_valid) begin
                pix_in_frame++;
                held = {7'b0, led_latch, led_data};
                if (exp_q.size() == 0) begin
                    check("pix_unexp", exp_q.size(), 1);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("pix", {7'b0, led_latch, led_data}, exp_v);
                end
            end else if (led_valid) begin
                check("hold", {7'b0, led_latch, led_data}, held);
            end
            if (led_valid) check("owner", grant, cur_owner);
            if (grant != 2'b00) check("busy_w_grant", busy, 1);
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                grant_cnt++;
                pix_in_frame = 0;
                cur_owner    = grant;
                if (exp_grant_q.size() == 0) check("grant_unexp", exp_grant_q.size(), 1);
                else                         check("grant", grant, exp_grant_q.pop_front());
                if (have_fd) check("gap", since_fd >= HOLDOFF, 1);
            end
            if (frame_done) begin
                check("fd_pulse", prev_fd, 0);
                check("fd_grant", grant, 0);
                check("frame_len", pix_in_frame, NUM_LEDS);
                frame_cnt++;
                have_fd  = 1;
                since_fd = 0;
            end else begin
                since_fd++;
            end
            if (stall_active) check("stall_nv", led_valid, 0);
            prev_valid = led_valid;
            prev_grant = grant;
            prev_fd    = frame_done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", led_valid, 0);
        check("rst_latch", led_latch, 0);
        check("rst_fd", frame_done, 0);
        check("rst_data", led_data, 0);
        check("rst_pix", pix_index, 0);
        check("rst_rdy", {src1_ready, src0_ready}, 0);
        check("rst_state", state_dbg, ST_IDLE);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        while (grant_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_grant", grant_cnt >= target, 1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_frame", frame_cnt >= target, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int x0, x1, g0, f0, n;
        rst_n = 1'b0; req = 2'b00; src0_valid = 1'b0; src1_valid = 1'b0;
        src0_data = '0; src1_data = '0; led_ready = 1'b1;
        apply_reset();

        // single source
        x0 = xfer0; g0 = grant_cnt; f0 = frame_cnt;
        exp_grant_q.push_back(2'b01); push_frame(0);
        req = 2'b01; src0_valid = 1'b1;
        wait_grants(g0 + 1, 50);
        req = 2'b00;
        wait_frames(f0 + 1, 300);
        repeat (HOLDOFF + 4) @(negedge clk);
        check("t1_grant_idle", grant, 0);
        check("t1_busy", busy, 0);
        check("t1_xfer0", xfer0 - x0, 4);
        check("t1_exp_left", exp_q.size(), 0);

        // round robin from a fresh reset
        apply_reset();
        x0 = xfer0; x1 = xfer1; g0 = grant_cnt; f0 = frame_cnt;
        exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b01);
        push_frame(0); push_frame(1); push_frame(0);
        req = 2'b11; src0_valid = 1'b1; src1_valid = 1'b1;
        wait_grants(g0 + 3, 1000);
        req = 2'b00;
        wait_frames(f0 + 3, 600);
        repeat (HOLDOFF + 4) @(negedge clk);
        check("t2_xfer0", xfer0 - x0, 8);
        check("t2_xfer1", xfer1 - x1, 4);
        check("t2_exp_left", exp_q.size() + exp_grant_q.size(), 0);

        // src1 stalls on pixel 2 while src0 keeps offering data
        x0 = xfer0; x1 = xfer1; g0 = grant_cnt; f0 = frame_cnt;
        exp_grant_q.push_back(2'b10); push_frame(1);
        stall_armed = 1; req = 2'b10;
        wait_grants(g0 + 1, 50);
        req = 2'b00;
        wait_frames(f0 + 1, 400);
        repeat (HOLDOFF + 4) @(negedge clk);
        check("t3_xfer0", xfer0 - x0, 0);
        check("t3_xfer1", xfer1 - x1, 4);
        check("t3_stall_done", stall_armed | stall_active, 0);
        check("t3_exp_left", exp_q.size(), 0);

        // request withdrawn after pixel 1
        src1_valid = 1'b0;
        x0 = xfer0; g0 = grant_cnt; f0 = frame_cnt;
        exp_grant_q.push_back(2'b01); push_frame(0);
        req = 2'b01;
        n = 0;
        while (!(grant == 2'b01 && pix_index == 2'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_pix1", pix_index, 1);
        req = 2'b00;
        wait_frames(f0 + 1, 300);
        repeat (HOLDOFF + 4) @(negedge clk);
        check("t4_busy", busy, 0);
        check("t4_grant", grant, 0);
        check("t4_state", state_dbg, ST_IDLE);
        check("t4_grants", grant_cnt - g0, 1);
        check("t4_xfer0", xfer0 - x0, 4);

        // reset in ISSUE of pixel 2 (src1 owns the frame after a src0 frame)
        src1_valid = 1'b1;
        x1 = xfer1;
        exp_grant_q.push_back(2'b10); push_frame(1);
        req = 2'b11;
        n = 0;
        while (!(state_dbg == ST_ISSUE && pix_index == 2'd2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_issue", state_dbg, ST_ISSUE);
        #1 rst_n = 1'b0;
        #1;
        check("t5_valid", led_valid, 0);
        check("t5_grant", grant, 0);
        check("t5_busy", busy, 0);
        check("t5_latch", led_latch, 0);
        check("t5_xfer1", xfer1 - x1, 3);
        exp_q.delete();
        exp_grant_q.delete();
        exp_grant_q.push_back(2'b01); push_frame(0);
        g0 = grant_cnt; f0 = frame_cnt; x0 = xfer0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_grants(g0 + 1, 50);
        req = 2'b00;
        wait_frames(f0 + 1, 300);
        repeat (HOLDOFF + 4) @(negedge clk);
        check("t5_xfer0", xfer0 - x0, 4);
        check("t5_exp_left", exp_q.size(), 0);

        // serializer backpressure at frame start
        src1_valid = 1'b0;
        ser_auto = 0; led_ready = 1'b0;
        f0 = frame_cnt;
        exp_grant_q.push_back(2'b01); push_frame(0);
        req = 2'b01;
        n = 0;
        while (!led_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_first_valid", led_valid, 1);
        req = 2'b00;
        x0 = xfer0;
        repeat (30) begin
            @(negedge clk);
            check("t6_valid_held", led_valid, 1);
            check("t6_rdy0", src0_ready, 0);
            check("t6_data", led_data, 24'h000011);
        end
        check("t6_no_xfer", xfer0 - x0, 0);
        ser_seen = 0; ser_busy = 0; led_ready = 1'b1; ser_auto = 1;
        wait_frames(f0 + 1, 300);
        repeat (HOLDOFF + 4) @(negedge clk);
        check("t6_xfer_rest", xfer0 - x0, 3);
        check("t6_exp_left", exp_q.size() + exp_grant_q.size(), 0);
        check("t6_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
